// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and a parity helper.
// Used by the transmitter and its bit timer, and later by the receiver.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   // Fixed encodings so existing register dumps and legacy tooling keep decoding the state.
   localparam logic [2:0] UART_ST_IDLE   = 3'd0;
   localparam logic [2:0] UART_ST_START  = 3'd1;
   localparam logic [2:0] UART_ST_DATA   = 3'd2;
   localparam logic [2:0] UART_ST_PARITY = 3'd3;
   localparam logic [2:0] UART_ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = UART_ST_IDLE,
      ST_START  = UART_ST_START,
      ST_DATA   = UART_ST_DATA,
      ST_PARITY = UART_ST_PARITY,
      ST_STOP   = UART_ST_STOP
   } uart_tx_state_t;

   // Callers zero-extend narrower words; the padding bits do not change the XOR.
   function automatic logic uart_parity(input logic [8:0] i_word, input logic i_odd);
      return (^i_word) ^ i_odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts s_tick pulses per bit period and flags the last tick; latency: bit_end is combinational on the OVERSAMPLE-th tick.
// No backpressure: clear has priority over counting, so a tick in a clear cycle is dropped.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic s_tick,
   input  logic clear,
   output logic bit_end
);

   localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last  = (r_cnt == LAST);
   assign bit_end = s_tick && w_last;

   // Explicit wrap keeps the period exact for non-power-of-two OVERSAMPLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (s_tick) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity (UART_TX_PARITY_EN), STOP_BITS stop; tx falls on the accept edge.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 s_tick,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_done,
   output logic                 busy
);

   localparam int            IW       = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (OVERSAMPLE < 2) begin : g_bad_oversample
      $error("uart_tx_frame: OVERSAMPLE must be at least 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
   end

   uart_tx_state_t       r_state;
   uart_tx_state_t       w_state_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic [IW-1:0]        r_idx;
   logic [IW-1:0]        w_idx_nxt;
   logic                 r_stop_cnt;
   logic                 w_stop_nxt;
   logic                 r_tx;
   logic                 w_tx_nxt;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 w_bit_end;
   logic                 w_timer_clr;

`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   // Timer is held at zero while idle and restarted on every state change,
   // which also discards a tick that lands on the acceptance cycle.
   assign w_timer_clr = (r_state == ST_IDLE) || (w_state_nxt != r_state);

   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .s_tick  (s_tick),
      .clear   (w_timer_clr),
      .bit_end (w_bit_end)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_stop_nxt  = r_stop_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tx_valid) begin
               w_state_nxt = ST_START;
               w_shift_nxt = data;
               w_idx_nxt   = '0;
               w_stop_nxt  = 1'b0;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state_nxt = ST_DATA;
               w_idx_nxt   = '0;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = r_shift >> 1;
               if (r_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
                  w_stop_nxt  = 1'b0;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = ST_STOP;
               w_stop_nxt  = 1'b0;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_end) begin
               if (STOP_BITS == 1 || r_stop_cnt) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_stop_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // tx is computed from the next state so the line register changes on the same edge as the FSM.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         ST_START: w_tx_nxt = 1'b0;
         ST_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_nxt = r_parity;
`endif
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_idx      <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_idx      <= w_idx_nxt;
         r_stop_cnt <= w_stop_nxt;
         r_tx       <= w_tx_nxt;
         r_done     <= w_done_nxt;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_parity <= 1'b0;
      end else if (r_state == ST_IDLE && tx_valid) begin
         r_parity <= uart_parity(9'(data), PARITY_ODD[0]);
      end
   end
`endif

   assign tx       = r_tx;
   assign tx_done  = r_done;
   assign tx_ready = (r_state == ST_IDLE);
   assign busy     = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7-bit/2-stop, odd-parity 8-bit) against a per-tick frame model.
// Directed table vectors plus random words and random tick spacing; corner sequences for reset, stall and back-to-back.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int OS = 16;

   logic       clk;
   logic       rst_n;
   logic       s_tick;
   logic [8:0] dat [3];
   logic [2:0] vld;
   logic [2:0] rdy_w;
   logic [2:0] tx_w;
   logic [2:0] done_w;
   logic [2:0] busy_w;

   int n_chk  = 0;
   int n_fail = 0;

   uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(OS), .PARITY_ODD(0)) u_dut0 (
      .clk(clk), .reset_n(rst_n), .s_tick(s_tick), .data(dat[0][7:0]), .tx_valid(vld[0]),
      .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_done(done_w[0]), .busy(busy_w[0]));

   uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(OS), .PARITY_ODD(0)) u_dut1 (
      .clk(clk), .reset_n(rst_n), .s_tick(s_tick), .data(dat[1][6:0]), .tx_valid(vld[1]),
      .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_done(done_w[1]), .busy(busy_w[1]));

   uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(OS), .PARITY_ODD(1)) u_dut2 (
      .clk(clk), .reset_n(rst_n), .s_tick(s_tick), .data(dat[2][7:0]), .tx_valid(vld[2]),
      .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_done(done_w[2]), .busy(busy_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic int db_of(input int d);
      return (d == 1) ? 7 : 8;
   endfunction
   function automatic int sb_of(input int d);
      return (d == 1) ? 2 : 1;
   endfunction
   function automatic int odd_of(input int d);
      return (d == 2) ? 1 : 0;
   endfunction
   function automatic int frame_len(input int d);
      return (1 + db_of(d) + PB + sb_of(d)) * OS;
   endfunction

   // Expected line level during bit period b of a frame carrying word w.
   function automatic logic exp_bit(input int d, input logic [8:0] w, input int b);
      int         db;
      logic [8:0] mask;
      db   = db_of(d);
      mask = (9'h1 << db) - 9'h1;
      if (b == 0) return 1'b0;
      if (b <= db) return w[b-1];
      if (PB == 1 && b == db + 1) return 1'((($countones(w & mask) + odd_of(d)) % 2));
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic tk);
      s_tick = tk;
      @(posedge clk);
      #1;
   endtask

   // Sends w on DUT d and follows the whole frame tick by tick against the model.
   task automatic run_frame(input int d, input logic [8:0] w, input int exp_len, input bit hold,
                            input int pulse_k, input int stall_k, output logic obs_par);
      int   nb, k, cyc, stall_left, par_k;
      int   errs [16];
      logic tk;
      nb         = 1 + db_of(d) + PB + sb_of(d);
      par_k      = (1 + db_of(d)) * OS + OS / 2;
      stall_left = 1000;
      obs_par    = 1'bx;
      tk         = 1'b0;
      for (int i = 0; i < 16; i++) errs[i] = 0;

      vld[d] = 1'b1;
      dat[d] = w;
      step(1'b1);
      chk($sformatf("d%0d accept_tx", d), tx_w[d], 0);
      chk($sformatf("d%0d accept_busy", d), {rdy_w[d], busy_w[d]}, 2'b01);
      chk($sformatf("d%0d accept_done", d), done_w[d], 0);
      if (!hold) vld[d] = 1'b0;
      dat[d] = 9'($urandom);

      k   = 0;
      cyc = 0;
      while (done_w[d] !== 1'b1 && cyc < 6000) begin
         if (k < nb * OS && tx_w[d] !== exp_bit(d, w, k / OS)) errs[k / OS]++;
         if (k == par_k) obs_par = tx_w[d];
         if (k == pulse_k) begin
            vld[d] = 1'b1;
            dat[d] = 9'($urandom);
         end else if (!hold) begin
            vld[d] = 1'b0;
         end
         if (k == stall_k && stall_left > 0) begin
            tk = 1'b0;
            stall_left--;
         end else begin
            tk = ($urandom_range(0, 2) == 0);
         end
         step(tk);
         cyc++;
         if (tk) k++;
      end

      chk($sformatf("d%0d done_seen", d), done_w[d], 1);
      chk($sformatf("d%0d done_on_tick", d), tk, 1);
      chk($sformatf("d%0d frame_ticks", d), k, exp_len);
      chk($sformatf("d%0d end_ready", d), {rdy_w[d], busy_w[d], tx_w[d]}, 3'b101);
      for (int b = 0; b < nb; b++) chk($sformatf("d%0d bit%0d_errs", d, b), errs[b], 0);

      if (!hold) begin
         vld[d] = 1'b0;
         step(1'b1);
         chk($sformatf("d%0d after_idle", d), {done_w[d], rdy_w[d], tx_w[d]}, 3'b011);
      end
   endtask

   typedef struct {
      int         d;
      logic [8:0] w;
      int         len;
      logic       par;
   } vec_t;

   initial begin
      vec_t       tbl [4];
      logic       par;
      int         k, cyc, d;
      logic [8:0] w;

      tbl[0] = '{d: 0, w: 9'h0A5, len: (10 + PB) * OS, par: 1'b0};
      tbl[1] = '{d: 0, w: 9'h007, len: (10 + PB) * OS, par: 1'b1};
      tbl[2] = '{d: 2, w: 9'h007, len: (10 + PB) * OS, par: 1'b0};
      tbl[3] = '{d: 1, w: 9'h07F, len: (10 + PB) * OS, par: 1'b1};

      rst_n  = 1'b0;
      s_tick = 1'b0;
      vld    = '0;
      for (int i = 0; i < 3; i++) dat[i] = '0;
      #23;
      for (int i = 0; i < 3; i++)
         chk($sformatf("d%0d reset_state", i), {tx_w[i], rdy_w[i], busy_w[i], done_w[i]}, 4'b1100);
      rst_n = 1'b1;
      step(1'b1);
      step(1'b0);

      for (int i = 0; i < 4; i++) begin
         run_frame(tbl[i].d, tbl[i].w, tbl[i].len, 1'b0, -1, -1, par);
`ifdef UART_TX_PARITY_EN
         chk($sformatf("vec%0d parity_bit", i), par, tbl[i].par);
`endif
      end

      // Back-to-back with tx_valid held: second frame must start the cycle after tx_done.
      run_frame(0, 9'h001, frame_len(0), 1'b1, -1, -1, par);
      run_frame(0, 9'h080, frame_len(0), 1'b0, -1, -1, par);

      // Mid-frame tx_valid pulse must not corrupt or queue anything.
      run_frame(0, 9'h0C3, frame_len(0), 1'b0, 40, -1, par);

      // Tick stall in START.
      run_frame(0, 9'h05A, frame_len(0), 1'b0, -1, 5, par);

      // Reset during data bit 3.
      w      = 9'h0F3;
      dat[0] = w;
      vld[0] = 1'b1;
      step(1'b1);
      vld[0] = 1'b0;
      k      = 0;
      cyc    = 0;
      while (k < 4 * OS + 5 && cyc < 2000) begin
         step(1'($urandom_range(0, 1)));
         cyc++;
         if (s_tick) k++;
      end
      chk("rst_pre_tx", tx_w[0], exp_bit(0, w, 4));
      s_tick = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {tx_w[0], rdy_w[0], busy_w[0], done_w[0]}, 4'b1100);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         chk($sformatf("rst_after%0d", i), {tx_w[0], rdy_w[0], done_w[0]}, 3'b110);
      end
      run_frame(0, 9'h03C, frame_len(0), 1'b0, -1, -1, par);

      for (int i = 0; i < 6; i++) begin
         d = $urandom_range(0, 2);
         w = 9'($urandom) & ((9'h1 << db_of(d)) - 9'h1);
         run_frame(d, w, frame_len(d), 1'b0, -1, -1, par);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
